pixel_capture: RTL and testbench

//  Stage directly downstream of the WS2812 bit decoder; consumes its shift_reg_t stream.
//  - Assembles the first BITS_PER_PIXEL decoded bits after a reset gap into one pixel word (GRB, MSB first).
//  - Presents the word on a valid/ready port and forwards all later bits of the frame to the daisy-chain re-encoder.

---
 rtl/pixel_capture.sv | 130 +++++++++++++
 tb/tb_pixel_capture.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_capture.sv
// Captures the first BITS_PER_PIXEL bits after a reset gap into a pixel word and forwards the rest of the frame.
// Latency: pixel and forwarded bit appear 1 cycle after the qualifying valid; treset has priority over valid.
// Backpressure: one-deep pixel holding register (valid/ready); unaccepted pixel is overwritten with o_overrun. Option: PIXEL_CAPTURE_FRAME_ERR_EN.
package pixel_capture_pkg;
    typedef struct packed {
        logic decoded_bit;
        logic valid;
        logic treset;
    } shift_reg_t;
endpackage

module pixel_capture
    import pixel_capture_pkg::*;
#(
    parameter int BITS_PER_PIXEL = 24
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  shift_reg_t                i_shift_reg,
    output logic [BITS_PER_PIXEL-1:0] o_pixel,
    output logic                      o_pixel_valid,
    input  logic                      i_pixel_ready,
    output logic                      o_fwd_bit,
    output logic                      o_fwd_valid,
    output logic                      o_overrun,
    output logic                      o_frame_err
);

    localparam int CW = $clog2(BITS_PER_PIXEL + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BITS_PER_PIXEL - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BITS_PER_PIXEL);

    typedef enum logic {
        CAPTURE = 1'b0,
        FORWARD = 1'b1
    } state_t;

    state_t                    state, state_nxt;
    logic [CW-1:0]             count, count_nxt;
    // The final bit of a pixel goes straight into o_pixel, so only BPP-1 bits are staged here.
    logic [BITS_PER_PIXEL-2:0] r_shift, shift_nxt;
    logic [BITS_PER_PIXEL-1:0] pixel_nxt;
    logic                      pixel_valid_nxt;
    logic                      fwd_bit_nxt;
    logic                      fwd_valid_nxt;
    logic                      overrun_nxt;
    logic                      accept;

    assign accept = o_pixel_valid && i_pixel_ready;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= CAPTURE;
            count         <= '0;
            r_shift       <= '0;
            o_pixel       <= '0;
            o_pixel_valid <= 1'b0;
            o_fwd_bit     <= 1'b0;
            o_fwd_valid   <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            state         <= state_nxt;
            count         <= count_nxt;
            r_shift       <= shift_nxt;
            o_pixel       <= pixel_nxt;
            o_pixel_valid <= pixel_valid_nxt;
            o_fwd_bit     <= fwd_bit_nxt;
            o_fwd_valid   <= fwd_valid_nxt;
            o_overrun     <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        count_nxt       = count;
        shift_nxt       = r_shift;
        pixel_nxt       = o_pixel;
        pixel_valid_nxt = o_pixel_valid && !i_pixel_ready;
        fwd_bit_nxt     = o_fwd_bit;
        fwd_valid_nxt   = 1'b0;
        overrun_nxt     = 1'b0;

        if (i_shift_reg.treset) begin
            state_nxt = CAPTURE;
            count_nxt = '0;
            shift_nxt = '0;
        end else if (i_shift_reg.valid) begin
            case (state)
                CAPTURE: begin
                    shift_nxt = {r_shift[BITS_PER_PIXEL-3:0], i_shift_reg.decoded_bit};
                    if (count != CNT_FULL) begin
                        count_nxt = count + CW'(1);
                    end
                    if (count == CNT_LAST) begin
                        state_nxt       = FORWARD;
                        pixel_nxt       = {r_shift, i_shift_reg.decoded_bit};
                        pixel_valid_nxt = 1'b1;
                        overrun_nxt     = o_pixel_valid && !accept;
                    end
                end
                FORWARD: begin
                    fwd_bit_nxt   = i_shift_reg.decoded_bit;
                    fwd_valid_nxt = 1'b1;
                end
                default: begin
                    state_nxt = CAPTURE;
                end
            endcase
        end
    end

`ifdef PIXEL_CAPTURE_FRAME_ERR_EN
    logic treset_q;

    // A reset gap that cuts a partially captured pixel short flags a truncated frame.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            treset_q    <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            treset_q    <= i_shift_reg.treset;
            o_frame_err <= i_shift_reg.treset && !treset_q && (state == CAPTURE)
                           && (count != '0) && (count != CNT_FULL);
        end
    end
`else
    assign o_frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_capture.sv
// Randomized and directed bench for pixel_capture against a frame-level reference model.
module tb_pixel_capture;
    import pixel_capture_pkg::*;

    localparam int BPP = 24;

    logic           i_clk = 1'b0;
    logic           i_reset_n = 1'b0;
    shift_reg_t     i_shift_reg = '0;
    logic [BPP-1:0] o_pixel;
    logic           o_pixel_valid;
    logic           i_pixel_ready = 1'b0;
    logic           o_fwd_bit;
    logic           o_fwd_valid;
    logic           o_overrun;
    logic           o_frame_err;

    pixel_capture #(.BITS_PER_PIXEL(BPP)) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_shift_reg   (i_shift_reg),
        .o_pixel       (o_pixel),
        .o_pixel_valid (o_pixel_valid),
        .i_pixel_ready (i_pixel_ready),
        .o_fwd_bit     (o_fwd_bit),
        .o_fwd_valid   (o_fwd_valid),
        .o_overrun     (o_overrun),
        .o_frame_err   (o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model: what the outputs must show after each rising edge.
    int             m_nbits = 0;
    int unsigned    m_acc = 0;
    logic [BPP-1:0] m_pixel = '0;
    logic           m_pvld = 1'b0;
    logic           m_fwd_vld = 1'b0;
    logic           m_fwd_bit = 1'b0;
    logic           m_overrun = 1'b0;
    logic           m_ferr = 1'b0;
    logic           m_prev_treset = 1'b0;

    // Observed activity, for the directed scenarios.
    int        n_ovr = 0;
    int        n_ferr = 0;
    int        n_fwd = 0;
    logic [7:0] fwd_hist = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, need 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge i_clk or negedge i_reset_n);
            if (!i_reset_n) begin
                m_nbits = 0; m_acc = 0; m_pixel = '0; m_pvld = 1'b0;
                m_fwd_vld = 1'b0; m_fwd_bit = 1'b0; m_overrun = 1'b0;
                m_ferr = 1'b0; m_prev_treset = 1'b0;
            end else begin
                automatic logic was_pending = m_pvld;
                automatic logic taken = m_pvld && i_pixel_ready;
                m_fwd_vld = 1'b0;
                m_overrun = 1'b0;
                m_ferr = 1'b0;
                if (taken) m_pvld = 1'b0;
                if (i_shift_reg.treset) begin
`ifdef PIXEL_CAPTURE_FRAME_ERR_EN
                    if (!m_prev_treset && m_nbits > 0 && m_nbits < BPP) m_ferr = 1'b1;
`endif
                    m_nbits = 0;
                    m_acc = 0;
                end else if (i_shift_reg.valid) begin
                    if (m_nbits < BPP) begin
                        m_acc = m_acc * 2 + 32'(i_shift_reg.decoded_bit);
                        m_nbits++;
                        if (m_nbits == BPP) begin
                            m_overrun = was_pending && !taken;
                            m_pixel = m_acc[BPP-1:0];
                            m_pvld = 1'b1;
                        end
                    end else begin
                        m_fwd_vld = 1'b1;
                        m_fwd_bit = i_shift_reg.decoded_bit;
                    end
                end
                m_prev_treset = i_shift_reg.treset;
            end
        end
    end

    initial begin
        forever begin
            @(negedge i_clk);
            if (o_overrun === 1'b1) n_ovr++;
            if (o_frame_err === 1'b1) n_ferr++;
            if (o_fwd_valid === 1'b1) begin
                n_fwd++;
                fwd_hist = {fwd_hist[6:0], o_fwd_bit};
            end
            if (chk_en) begin
                check("pixel_valid", 32'(o_pixel_valid), 32'(m_pvld));
                check("pixel", 32'(o_pixel), 32'(m_pixel));
                check("fwd_valid", 32'(o_fwd_valid), 32'(m_fwd_vld));
                if (m_fwd_vld) check("fwd_bit", 32'(o_fwd_bit), 32'(m_fwd_bit));
                check("overrun", 32'(o_overrun), 32'(m_overrun));
                check("frame_err", 32'(o_frame_err), 32'(m_ferr));
            end
        end
    end

    task automatic drive(input logic b, input logic v, input logic t, input logic r);
        i_shift_reg = '{decoded_bit: b, valid: v, treset: t};
        i_pixel_ready = r;
        @(negedge i_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] val, input int n, input logic r, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            drive(val[i], 1'b1, 1'b0, r);
            repeat (gap) drive(1'b0, 1'b0, 1'b0, r);
        end
    endtask

    task automatic gap_cycles(input int n, input logic r);
        repeat (n) drive(1'b0, 1'b0, 1'b1, r);
    endtask

    int base_ovr, base_ferr, base_fwd, exp_ferr;

    initial begin
`ifdef PIXEL_CAPTURE_FRAME_ERR_EN
        exp_ferr = 1;
`else
        exp_ferr = 0;
`endif
        // Reset state with the line held in a reset gap.
        i_shift_reg = '{decoded_bit: 1'b0, valid: 1'b0, treset: 1'b1};
        repeat (3) @(negedge i_clk);
        #1;
        check("rst_pixel", 32'(o_pixel), 32'h0);
        check("rst_pixel_valid", 32'(o_pixel_valid), 32'h0);
        check("rst_fwd_valid", 32'(o_fwd_valid), 32'h0);
        check("rst_overrun", 32'(o_overrun), 32'h0);
        i_reset_n = 1'b1;
        chk_en = 1'b1;
        gap_cycles(2, 1'b1);

        // Basic capture, accepted immediately.
        send(32'hA5C33C, BPP, 1'b1, 0);
        check("s1_pixel", 32'(o_pixel), 32'hA5C33C);
        check("s1_valid_set", 32'(o_pixel_valid), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("s1_valid_clr", 32'(o_pixel_valid), 32'h0);

        // Capture then forward the rest of the frame.
        gap_cycles(2, 1'b1);
        base_fwd = n_fwd;
        send(32'h0F0F0F, BPP, 1'b0, 0);
        send(32'hF0, 8, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("s2_fwd_count", 32'(n_fwd - base_fwd), 32'd8);
        check("s2_fwd_bits", 32'(fwd_hist), 32'hF0);
        check("s2_pixel_kept", 32'(o_pixel), 32'h0F0F0F);
        check("s2_valid_held", 32'(o_pixel_valid), 32'h1);

        // Overwrite of an unaccepted pixel.
        gap_cycles(2, 1'b1);
        base_ovr = n_ovr;
        send(32'h000001, BPP, 1'b0, 0);
        gap_cycles(1, 1'b0);
        send(32'h000002, BPP, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("s3_pixel", 32'(o_pixel), 32'h000002);
        check("s3_valid_held", 32'(o_pixel_valid), 32'h1);
        check("s3_overrun_pulses", 32'(n_ovr - base_ovr), 32'd1);

        // Partial frame is discarded.
        gap_cycles(2, 1'b1);
        base_ovr = n_ovr;
        base_ferr = n_ferr;
        send(32'h2AB, 10, 1'b1, 0);
        gap_cycles(3, 1'b0);
        send(32'h123456, BPP, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("s4_pixel", 32'(o_pixel), 32'h123456);
        check("s4_overrun_none", 32'(n_ovr - base_ovr), 32'd0);
        check("s4_frame_err", 32'(n_ferr - base_ferr), 32'(exp_ferr));

        // treset wins over a coincident valid.
        gap_cycles(2, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        send(32'hABCDEF, BPP, 1'b1, 0);
        check("s5_pixel", 32'(o_pixel), 32'hABCDEF);
        check("s5_valid", 32'(o_pixel_valid), 32'h1);

        // Asynchronous reset mid-frame with a pixel pending.
        gap_cycles(2, 1'b1);
        send(32'h777777, BPP, 1'b0, 0);
        send(32'h15, 5, 1'b0, 0);
        i_reset_n = 1'b0;
        #1;
        check("s6_pixel_zero", 32'(o_pixel), 32'h0);
        check("s6_valid_zero", 32'(o_pixel_valid), 32'h0);
        check("s6_fwd_zero", 32'(o_fwd_valid), 32'h0);
        check("s6_fwdbit_zero", 32'(o_fwd_bit), 32'h0);
        check("s6_overrun_zero", 32'(o_overrun), 32'h0);
        check("s6_ferr_zero", 32'(o_frame_err), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        i_reset_n = 1'b1;
        send(32'h5A5A5A, BPP, 1'b0, 0);
        check("s6_recapture", 32'(o_pixel), 32'h5A5A5A);
        check("s6_recapture_vld", 32'(o_pixel_valid), 32'h1);

        // Random traffic checked every cycle against the model.
        for (int c = 0; c < 4000; c++) begin
            drive(1'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 3) != 0));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
